// File: rtl/rv_pkg.sv
// Shared definitions for the RV64I decode stage.
//   - Opcode constants for the supported instruction classes.
//   - alu_op encodings consumed by the ALU-control/ALU block.
//   - dec_t: packed control word produced by rv_decode_comb and carried
//     through the skid buffer (the immediate travels alongside it so the
//     struct stays independent of XLEN).
package rv_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] f3;
        logic [1:0] f7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV64I subset decoder.
// Ports:
//   i_instr  32-bit instruction word
//   o_dec    decoded control word (dec_t)
//   o_imm    XLEN-bit sign-extended immediate (0 for R-type / illegal)
// Supported: R-type add/sub/and/or, ld, sd, beq. Everything else is flagged
// illegal with all enables cleared; register and funct fields are still
// extracted so downstream debug sees the raw indices.
module rv_decode_comb
    import rv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     i_instr,
    output dec_t            o_dec,
    output logic [XLEN-1:0] o_imm
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [11:0] w_imm_i;
    logic [11:0] w_imm_s;
    logic [12:0] w_imm_b;
    logic        w_r_ok;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_imm_i  = i_instr[31:20];
    assign w_imm_s  = {i_instr[31:25], i_instr[11:7]};
    assign w_imm_b  = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};

    // funct7=0100000 (sub) is only meaningful together with funct3=000.
    assign w_r_ok = ((w_funct3 == 3'b000) || (w_funct3 == 3'b111) || (w_funct3 == 3'b110)) &&
                    ((w_funct7 == 7'b0000000) ||
                     ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000)));

    always_comb begin
        o_dec         = '0;
        o_imm         = '0;
        o_dec.f3      = w_funct3[1:0];
        o_dec.f7      = {1'b0, w_funct7[5]};
        o_dec.rd      = i_instr[11:7];
        o_dec.rs1     = i_instr[19:15];
        o_dec.rs2     = i_instr[24:20];
        o_dec.alu_op  = ALUOP_ADD;
        o_dec.illegal = 1'b1;
        case (w_opcode)
            OP_R: begin
                if (w_r_ok) begin
                    o_dec.illegal   = 1'b0;
                    o_dec.alu_op    = ALUOP_RTYPE;
                    o_dec.reg_write = 1'b1;
                end
            end
            OP_LD: begin
                if (w_funct3 == 3'b011) begin
                    o_dec.illegal   = 1'b0;
                    o_dec.alu_op    = ALUOP_ADD;
                    o_dec.alu_src   = 1'b1;
                    o_dec.mem_read  = 1'b1;
                    o_dec.reg_write = 1'b1;
                    o_imm           = {{(XLEN-12){w_imm_i[11]}}, w_imm_i};
                end
            end
            OP_ST: begin
                if (w_funct3 == 3'b011) begin
                    o_dec.illegal   = 1'b0;
                    o_dec.alu_op    = ALUOP_ADD;
                    o_dec.alu_src   = 1'b1;
                    o_dec.mem_write = 1'b1;
                    o_imm           = {{(XLEN-12){w_imm_s[11]}}, w_imm_s};
                end
            end
            OP_BR: begin
                if (w_funct3 == 3'b000) begin
                    o_dec.illegal = 1'b0;
                    o_dec.alu_op  = ALUOP_SUB;
                    o_dec.branch  = 1'b1;
                    o_imm         = {{(XLEN-13){w_imm_b[12]}}, w_imm_b};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer.
// Ports:
//   clk, rst_n (async active-low), flush (sync discard of buffered entries)
//   in_valid/in_ready/instr       upstream handshake + instruction word
//   out_valid/out_ready           downstream handshake
//   alu_op, f3, f7, rd, rs1, rs2, imm, alu_src, reg_write, mem_read,
//   mem_write, branch, illegal    decoded word held in the main entry
//   illegal_cnt                   saturating count of accepted illegal words
// The main entry M drives the outputs; the skid entry S absorbs one word when
// the consumer stalls. in_ready is simply !S.valid, so it is a register output
// with no combinational path from out_ready.
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       alu_op,
    output logic [1:0]       f3,
    output logic [1:0]       f7,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [XLEN-1:0]  imm,
    output logic             alu_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    dec_t            w_dec;
    logic [XLEN-1:0] w_imm;
    logic            w_accept;
    logic            w_xfer;

    logic             r_m_valid;
    dec_t             r_m_dec;
    logic [XLEN-1:0]  r_m_imm;
    logic             r_s_valid;
    dec_t             r_s_dec;
    logic [XLEN-1:0]  r_s_imm;
    logic [CNT_W-1:0] r_illegal_cnt;

    rv_decode_comb #(.XLEN(XLEN)) u_dec (
        .i_instr (instr),
        .o_dec   (w_dec),
        .o_imm   (w_imm)
    );

    assign in_ready  = !r_s_valid;
    assign out_valid = r_m_valid;
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = r_m_valid && out_ready;

    // Data fields are never cleared on drain or flush, so the outputs keep
    // their last value while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_dec   <= '0;
            r_m_imm   <= '0;
            r_s_valid <= 1'b0;
            r_s_dec   <= '0;
            r_s_imm   <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (w_xfer) begin
            if (r_s_valid) begin
                // in_ready is low here, so no accept can coincide.
                r_m_dec   <= r_s_dec;
                r_m_imm   <= r_s_imm;
                r_s_valid <= 1'b0;
            end else if (w_accept) begin
                r_m_dec <= w_dec;
                r_m_imm <= w_imm;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_m_valid) begin
                r_m_valid <= 1'b1;
                r_m_dec   <= w_dec;
                r_m_imm   <= w_imm;
            end else begin
                r_s_valid <= 1'b1;
                r_s_dec   <= w_dec;
                r_s_imm   <= w_imm;
            end
        end
    end

    // Counts words actually taken in; a flushed word was never taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_accept && !flush && w_dec.illegal &&
                     (r_illegal_cnt != {CNT_W{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    assign alu_op      = r_m_dec.alu_op;
    assign f3          = r_m_dec.f3;
    assign f7          = r_m_dec.f7;
    assign rd          = r_m_dec.rd;
    assign rs1         = r_m_dec.rs1;
    assign rs2         = r_m_dec.rs2;
    assign imm         = r_m_imm;
    assign alu_src     = r_m_dec.alu_src;
    assign reg_write   = r_m_dec.reg_write;
    assign mem_read    = r_m_dec.mem_read;
    assign mem_write   = r_m_dec.mem_write;
    assign branch      = r_m_dec.branch;
    assign illegal     = r_m_dec.illegal;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: hand-computed expected values for each
// instruction, stall/ordering, flush and asynchronous reset behaviour.
module tb_rv_decode_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 8;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_LD   = 32'h00813283;
    localparam logic [31:0] I_SD   = 32'hFE513C23;
    localparam logic [31:0] I_BEQ  = 32'h00208863;
    localparam logic [31:0] I_ADDI = 32'h00000013;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       alu_op;
    logic [1:0]       f3;
    logic [1:0]       f7;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [XLEN-1:0]  imm;
    logic             alu_src;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int checks   = 0;
    int failures = 0;

    rv_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .f3          (f3),
        .f7          (f7),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .alu_src     (alu_src),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'h0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
        chk("rst_imm", imm, 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // add x3,x1,x2: one cycle accept-to-valid
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = I_ADD;
        tick();
        $display("txn add: out_valid=%0b alu_op=%0b rd=%0d", out_valid, alu_op, rd);
        chk("add_out_valid", 64'(out_valid), 64'd1);
        chk("add_alu_op", 64'(alu_op), 64'd2);
        chk("add_f3", 64'(f3), 64'd0);
        chk("add_f7", 64'(f7), 64'd0);
        chk("add_rd", 64'(rd), 64'd3);
        chk("add_rs1", 64'(rs1), 64'd1);
        chk("add_rs2", 64'(rs2), 64'd2);
        chk("add_reg_write", 64'(reg_write), 64'd1);
        chk("add_alu_src", 64'(alu_src), 64'd0);
        chk("add_imm", imm, 64'd0);

        // sub then and, back to back
        instr = I_SUB;
        tick();
        $display("txn sub: f3=%0b f7=%0b", f3, f7);
        chk("sub_out_valid", 64'(out_valid), 64'd1);
        chk("sub_f7", 64'(f7), 64'd1);
        chk("sub_f3", 64'(f3), 64'd0);
        instr = I_AND;
        tick();
        $display("txn and: f3=%0b f7=%0b", f3, f7);
        chk("and_out_valid", 64'(out_valid), 64'd1);
        chk("and_f7", 64'(f7), 64'd0);
        chk("and_f3", 64'(f3), 64'd3);
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("hold_f3", 64'(f3), 64'd3);

        // ld x5,8(x2)
        in_valid = 1'b1;
        instr    = I_LD;
        tick();
        $display("txn ld: imm=0x%0h rd=%0d", imm, rd);
        chk("ld_alu_op", 64'(alu_op), 64'd0);
        chk("ld_imm", imm, 64'd8);
        chk("ld_alu_src", 64'(alu_src), 64'd1);
        chk("ld_mem_read", 64'(mem_read), 64'd1);
        chk("ld_reg_write", 64'(reg_write), 64'd1);
        chk("ld_rd", 64'(rd), 64'd5);
        chk("ld_rs1", 64'(rs1), 64'd2);

        // sd x5,-8(x2)
        instr = I_SD;
        tick();
        $display("txn sd: imm=0x%0h", imm);
        chk("sd_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("sd_mem_write", 64'(mem_write), 64'd1);
        chk("sd_mem_read", 64'(mem_read), 64'd0);
        chk("sd_reg_write", 64'(reg_write), 64'd0);
        chk("sd_rs2", 64'(rs2), 64'd5);

        // beq x1,x2,+16
        instr = I_BEQ;
        tick();
        $display("txn beq: imm=0x%0h branch=%0b", imm, branch);
        chk("beq_alu_op", 64'(alu_op), 64'd1);
        chk("beq_branch", 64'(branch), 64'd1);
        chk("beq_imm", imm, 64'd16);
        chk("beq_alu_src", 64'(alu_src), 64'd0);

        // addi: unsupported
        instr = I_ADDI;
        tick();
        $display("txn addi: illegal=%0b cnt=%0d", illegal, illegal_cnt);
        chk("addi_illegal", 64'(illegal), 64'd1);
        chk("addi_cnt", 64'(illegal_cnt), 64'd1);
        chk("addi_alu_op", 64'(alu_op), 64'd0);
        chk("addi_imm", imm, 64'd0);
        chk("addi_reg_write", 64'(reg_write), 64'd0);
        chk("addi_branch", 64'(branch), 64'd0);
        in_valid = 1'b0;
        tick();
        chk("addi_drain", 64'(out_valid), 64'd0);

        // stall with three words
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = I_ADD;
        tick();
        chk("stall_w1_in_ready", 64'(in_ready), 64'd1);
        instr = I_SUB;
        tick();
        $display("txn stall: in_ready=%0b f7=%0b", in_ready, f7);
        chk("stall_full_in_ready", 64'(in_ready), 64'd0);
        chk("stall_full_out_valid", 64'(out_valid), 64'd1);
        chk("stall_full_f7", 64'(f7), 64'd0);
        instr = I_AND;
        tick();
        chk("stall_w3_in_ready", 64'(in_ready), 64'd0);
        chk("stall_w3_f7", 64'(f7), 64'd0);
        chk("stall_w3_f3", 64'(f3), 64'd0);
        out_ready = 1'b1;
        tick();
        $display("txn release1: f3=%0b f7=%0b", f3, f7);
        chk("rel1_f7", 64'(f7), 64'd1);
        chk("rel1_in_ready", 64'(in_ready), 64'd1);
        chk("rel1_out_valid", 64'(out_valid), 64'd1);
        tick();
        $display("txn release2: f3=%0b f7=%0b", f3, f7);
        chk("rel2_f3", 64'(f3), 64'd3);
        chk("rel2_f7", 64'(f7), 64'd0);
        chk("rel2_out_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("rel3_out_valid", 64'(out_valid), 64'd0);
        chk("rel3_cnt", 64'(illegal_cnt), 64'd1);

        // fill both entries, then flush with in_valid high
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = I_ADD;
        tick();
        instr = I_SUB;
        tick();
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        instr = I_ADDI;
        tick();
        $display("txn flush: out_valid=%0b in_ready=%0b", out_valid, in_ready);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        // flush while in_ready is high: incoming illegal word is discarded
        tick();
        chk("flush2_out_valid", 64'(out_valid), 64'd0);
        chk("flush2_cnt", 64'(illegal_cnt), 64'd1);
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_flush_cnt", 64'(illegal_cnt), 64'd2);
        chk("post_flush_valid", 64'(out_valid), 64'd1);

        // saturation of the illegal counter
        for (int i = 0; i < 252; i++) tick();
        chk("cnt_254", 64'(illegal_cnt), 64'd254);
        for (int i = 0; i < 5; i++) tick();
        $display("txn saturate: cnt=%0d", illegal_cnt);
        chk("cnt_sat", 64'(illegal_cnt), 64'd255);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        instr     = I_LD;
        tick();
        tick();
        chk("prerst_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn async_reset: out_valid=%0b cnt=%0d", out_valid, illegal_cnt);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_cnt", 64'(illegal_cnt), 64'd0);
        chk("arst_imm", imm, 64'd0);
        chk("arst_rd", 64'(rd), 64'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered instruction-decode stage that produces the control word consumed by the combined ALU-control/ALU block: alu_op, 2-bit f3, 2-bit f7, register indices, a 64-bit sign-extended immediate and datapath enables.
- Sits between instruction fetch and the execute stage.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so in_ready never depends combinationally on out_ready.

Parameters:
- XLEN, 64, datapath/immediate width
- CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  instruction present
- in_ready  output  1  stage can accept
- instr  input  32  RV64I instruction word
- out_valid  output  1  decoded word present
- out_ready  input  1  execute stage accepts
- alu_op  output  2  00 add (load/store), 01 sub (branch), 10 R-type (use f3/f7)
- f3  output  2  funct3[1:0]
- f7  output  2  {1'b0, funct7[5]}
- rd, rs1, rs2  output  5 each  register indices
- imm  output  XLEN  sign-extended immediate
- alu_src  output  1  operand B from imm
- reg_write, mem_read, mem_write, branch  output  1 each  control enables
- illegal  output  1  unsupported encoding
- illegal_cnt  output  CNT_W  saturating count of illegal words accepted

Behaviour:
- Reset (rst_n low, asynchronous): both buffer entries invalid; out_valid=0; in_ready=1; all decoded outputs 0; illegal_cnt=0.
- Decoded outputs are held at their last value while out_valid=0.
- Decode, keyed on opcode plus funct3/funct7:
  - 0110011 R-type, funct3 in {000,111,110}, funct7 in {0000000, 0100000 only with funct3 000}: alu_op=10, reg_write=1, alu_src=0, imm=0.
  - 0000011 ld (funct3 011): alu_op=00, alu_src=1, mem_read=1, reg_write=1, imm=sext(instr[31:20]).
  - 0100011 sd (funct3 011): alu_op=00, alu_src=1, mem_write=1, imm=sext({instr[31:25],instr[11:7]}).
  - 1100011 beq (funct3 000): alu_op=01, branch=1, imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - Anything else: illegal=1; all enables 0; alu_op=00; imm=0; register fields still extracted.
- Buffering:
  - Main register M drives the outputs; skid register S.
  - in_ready = !S.valid, a registered signal.
  - Accept when in_valid && in_ready. Decode is combinational from instr and written into M if M is empty or draining this cycle, otherwise into S.
  - Output transfer when out_valid && out_ready; on transfer, S moves into M.
  - Latency: 1 cycle from accept to out_valid with M empty.
  - Throughput: 1 word/cycle with out_ready=1.
- Boundaries:
  - Both entries full with out_ready=0: in_ready=0; M and S held stable.
  - Simultaneous accept and transfer with S full is impossible because in_ready=0.
  - Simultaneous accept and transfer with S empty: the new word goes straight into M.
  - Order preserved; no drop or duplicate.
- flush has priority over accept and transfer in the same cycle: M and S invalidated, the incoming word discarded, illegal_cnt unchanged by the discarded word.
- illegal_cnt increments on accept of an illegal word and saturates at 2^CNT_W-1. It is not cleared by flush.
- Reset mid-operation: entries dropped immediately (asynchronous).

Decomposition:
- Shared package rv_pkg: opcode constants (OP_R, OP_LD, OP_ST, OP_BR), alu_op encodings (ALUOP_ADD/SUB/RTYPE), and a packed decoded-word struct holding the control fields.
- Sub-module rv_decode_comb: pure combinational instr-to-struct decode, reusable by the bench as the golden model.
- rv_decode_stage itself owns only the skid buffer and the counter.

Test Plan:
- 0x002081B3 (add x3,x1,x2), out_ready=1 -> one cycle later out_valid=1, alu_op=10, f3=00, f7=00, rd=3, rs1=1, rs2=2, reg_write=1.
- 0x402081B3 (sub) then 0x0020F1B3 (and) back to back -> consecutive cycles: f7=01, f3=00; then f7=00, f3=11.
- 0x00813283 (ld x5,8(x2)) -> alu_op=00, imm=8, alu_src=1, mem_read=1, reg_write=1, rd=5. Then 0xFE513C23 (sd x5,-8(x2)) -> imm=0xFFFFFFFFFFFFFFF8, mem_write=1, reg_write=0.
- 0x00208863 (beq x1,x2,+16) -> alu_op=01, branch=1, imm=16. Then 0x00000013 (addi, unsupported) -> illegal=1, illegal_cnt=1.
- out_ready=0 while streaming 3 words -> two accepted, in_ready=0 on the third and outputs stable. Raise out_ready -> all 3 delivered in order.
- Two entries full, then flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1. Separately, rst_n pulsed low mid-stream -> outputs and illegal_cnt cleared asynchronously.
